dpram_ctl: RTL

//  Parametrised true dual-port block RAM, successor to the fixed 16x1024 dual-port RAM.

---
 rtl/dpram_ctl.sv | 119 +++++++++++
 1 files changed

// File: rtl/dpram_ctl.sv
// rtl/dpram_ctl.sv - parametrised true dual-port RAM with byte enables and clear sequencer
// Port A has priority on overlapping byte writes; CLEAR zeroes every word before ready.
module dpram_ctl #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 10,
  parameter int RDW_MODE = 0,
  parameter int CLEAR_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_A,
  input  logic                  we_A,
  input  logic [DATA_W/8-1:0]   be_A,
  input  logic [ADDR_W-1:0]     addr_A,
  input  logic [DATA_W-1:0]     data_A,
  output logic [DATA_W-1:0]     out_A,
  output logic                  valid_A,
  input  logic                  en_B,
  input  logic                  we_B,
  input  logic [DATA_W/8-1:0]   be_B,
  input  logic [ADDR_W-1:0]     addr_B,
  input  logic [DATA_W-1:0]     data_B,
  output logic [DATA_W-1:0]     out_B,
  output logic                  valid_B,
  output logic                  ready,
  output logic                  collision
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {S_CLEAR, S_IDLE_WAIT, S_RUN} state_t;

  state_t             r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_clr_addr;
  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [DATA_W-1:0]  r_out_A, r_out_B;
  logic               r_valid_A, r_valid_B, r_collision;

  logic               w_ready, w_clr_we;
  logic               w_acc_A, w_acc_B, w_wr_A, w_wr_B, w_same_wr;
  logic [DATA_W-1:0]  w_old_A, w_old_B, w_own_A, w_own_B, w_store_A;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= (CLEAR_EN != 0) ? S_CLEAR : S_IDLE_WAIT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr_we    = 1'b0;
    unique case (r_state)
      S_CLEAR: begin
        w_clr_we = 1'b1;
        if (&r_clr_addr) w_state_nxt = S_RUN;
      end
      S_IDLE_WAIT: w_state_nxt = S_RUN;
      default:     w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_clr_addr <= '0;
    else if (w_clr_we) r_clr_addr <= r_clr_addr + ADDR_W'(1);
  end

  assign w_ready   = (r_state == S_RUN);
  assign w_acc_A   = w_ready & en_A;
  assign w_acc_B   = w_ready & en_B;
  assign w_wr_A    = w_acc_A & we_A;
  assign w_wr_B    = w_acc_B & we_B;
  assign w_same_wr = w_wr_B & (addr_A == addr_B);

  // w_own_* merges only the port's own bytes (its write-first view);
  // w_store_A also folds in B's bytes so A's store is the final word on a shared address.
  always_comb begin
    w_old_A   = r_mem[addr_A];
    w_old_B   = r_mem[addr_B];
    w_own_A   = w_old_A;
    w_own_B   = w_old_B;
    w_store_A = w_old_A;
    for (int i = 0; i < NB; i++) begin
      if (be_A[i]) w_own_A[8*i +: 8] = data_A[8*i +: 8];
      if (be_B[i]) w_own_B[8*i +: 8] = data_B[8*i +: 8];
      if (be_A[i])                   w_store_A[8*i +: 8] = data_A[8*i +: 8];
      else if (w_same_wr && be_B[i]) w_store_A[8*i +: 8] = data_B[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr_we) r_mem[r_clr_addr] <= '0;
    if (w_wr_B)   r_mem[addr_B]     <= w_own_B;
    if (w_wr_A)   r_mem[addr_A]     <= w_store_A;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_A     <= '0;
      r_out_B     <= '0;
      r_valid_A   <= 1'b0;
      r_valid_B   <= 1'b0;
      r_collision <= 1'b0;
    end else begin
      r_valid_A   <= w_acc_A;
      r_valid_B   <= w_acc_B;
      r_collision <= w_wr_A & w_wr_B & (addr_A == addr_B) & (|(be_A & be_B));
      if (w_acc_A) r_out_A <= (we_A && RDW_MODE == 0) ? w_own_A : w_old_A;
      if (w_acc_B) r_out_B <= (we_B && RDW_MODE == 0) ? w_own_B : w_old_B;
    end
  end

  assign out_A     = r_out_A;
  assign out_B     = r_out_B;
  assign valid_A   = r_valid_A;
  assign valid_B   = r_valid_B;
  assign ready     = w_ready;
  assign collision = r_collision;

endmodule
